// File: rtl/game_supervisor_pkg.sv
// Shared definitions for the game supervisor.
// Holds the FSM state encoding, the active-low seven-segment glyphs
// ({g,f,e,d,c,b,a}), the clock-cycles-per-millisecond derivation and the
// saturating three-digit BCD increment used for the score.
package game_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PLAY = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [11:0] SCORE_MAX = 12'h999;

    function automatic int cycles_per_ms(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    // Add one to a three-digit BCD value with carry; holds at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        if (s != SCORE_MAX) begin
            if (s[3:0] != 4'd9) begin
                r[3:0] = s[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (s[7:4] != 4'd9) begin
                    r[7:4] = s[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = s[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_supervisor_seg7_decoder.sv
// Combinational BCD to seven-segment decoder.
// Ports: bcd  - 4-bit digit code (0-9 shown, anything else blank)
//        seg  - active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
    import game_supervisor_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/game_supervisor.sv
// Game supervisor: sequences a round (IDLE -> ARM -> PLAY -> OVER), pulses
// the game-core reset, keeps a BCD score and multiplexes a 4-digit display.
// Ports: clk, reset (sync, active-high), start (one-cycle button pulse),
//        killingAlien (one-cycle pulse), victory/defeat (level flags),
//        gameReset (core reset), state (FSM state, also the debug view),
//        score (3 BCD digits), seg (active-low glyph), an (active-low enable).
module game_supervisor #(
    parameter int CLK_FREQ   = 100000000,
    parameter int SCAN_HZ    = 1000,
    parameter int HOLDOFF_MS = 1000,
    parameter int RST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        killingAlien,
    input  logic        victory,
    input  logic        defeat,
    output logic        gameReset,
    output logic [1:0]  state,
    output logic [11:0] score,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    import game_supervisor_pkg::*;

    localparam int SCAN_DIV    = (CLK_FREQ / SCAN_HZ > 0) ? CLK_FREQ / SCAN_HZ : 1;
    localparam int SCAN_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_CYCLES = HOLDOFF_MS * cycles_per_ms(CLK_FREQ);
    localparam int HOLD_W      = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int ARM_LAST    = (RST_CYCLES > 1) ? RST_CYCLES - 1 : 0;
    localparam int ARM_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e              state_q, state_d;
    logic                won_q, won_d;
    logic [11:0]         score_q, score_d;
    logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          digit_q, digit_d;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          an_q, an_d;
    logic [3:0]          dec_bcd;
    logic [6:0]          dec_seg;
    logic [6:0]          status_seg;

    // Next-state, score and scan logic.
    always_comb begin
        state_d    = state_q;
        won_d      = won_q;
        score_d    = score_q;
        arm_cnt_d  = '0;
        hold_d     = hold_q;
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        digit_d    = digit_q;

        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    score_d = '0;
                    won_d   = 1'b0;
                end
            end
            ST_ARM: begin
                // gameReset follows ST_ARM, so ARM lasts exactly RST_CYCLES.
                if (arm_cnt_q == ARM_W'(ARM_LAST)) begin
                    state_d = ST_PLAY;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_PLAY: begin
                // A kill on the exit cycle still counts.
                if (killingAlien) begin
                    score_d = bcd_inc(score_q);
                end
                if (defeat) begin
                    state_d = ST_OVER;
                    won_d   = 1'b0;
                    hold_d  = HOLD_W'(HOLD_CYCLES);
                end else if (victory) begin
                    state_d = ST_OVER;
                    won_d   = 1'b1;
                    hold_d  = HOLD_W'(HOLD_CYCLES);
                end
            end
            ST_OVER: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (start) begin
                    state_d = ST_ARM;
                    score_d = '0;
                    won_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Display path works from next-state values so the registered glyph and
    // enable always describe the same digit in the same cycle.
    always_comb begin
        dec_bcd = 4'hF;
        case (digit_d)
            2'd0:    dec_bcd = score_d[3:0];
            2'd1:    dec_bcd = score_d[7:4];
            2'd2:    dec_bcd = score_d[11:8];
            default: dec_bcd = 4'hF;
        endcase
    end

    seg7_decoder u_dec (
        .bcd (dec_bcd),
        .seg (dec_seg)
    );

    always_comb begin
        status_seg = SEG_BLANK;
        case (state_d)
            ST_IDLE: status_seg = SEG_DASH;
            ST_OVER: status_seg = won_d ? SEG_U : SEG_L;
            default: status_seg = SEG_BLANK;
        endcase
        seg_d = (digit_d == 2'd3) ? status_seg : dec_seg;
        an_d  = ~(4'b0001 << digit_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            won_q      <= 1'b0;
            score_q    <= '0;
            arm_cnt_q  <= '0;
            hold_q     <= '0;
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            seg_q      <= SEG_0;
            an_q       <= 4'b1110;
        end else begin
            state_q    <= state_d;
            won_q      <= won_d;
            score_q    <= score_d;
            arm_cnt_q  <= arm_cnt_d;
            hold_q     <= hold_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    // Held high by the supervisor's own reset as well as throughout ARM.
    assign gameReset = reset | (state_q == ST_ARM);
    assign state     = state_q;
    assign score     = score_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
